// File: rtl/sm16_add_unit.sv
// Registered 16-bit sign-magnitude adder: operands go to two's complement, pass
// through a two-level carry-lookahead adder, and the sum returns to sign-magnitude.

module complement (
  input  logic [15:0] x,
  output logic [15:0] y
);
  logic [14:0] neg_mag;

  assign neg_mag = ~x[14:0] + 15'd1;
  assign y       = x[15] ? {1'b1, neg_mag} : x;
endmodule

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] pb;
  logic [3:0] gb;
  logic [3:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  assign c[0] = cin;
  assign c[1] = gb[0] | (pb[0] & cin);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & cin);

  assign s  = pb ^ c;
  assign pg = &pb;
  assign gg = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0]);
endmodule

module cla_lookahead (
  input  logic [3:0] sp,
  input  logic [3:0] sg,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);
  // c[k] is the carry into slice k+1 (c4, c8, c12, c16); all computed in parallel.
  assign c[0] = sg[0] | (sp[0] & cin);
  assign c[1] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & cin);
  assign c[2] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
              | (sp[2] & sp[1] & sp[0] & cin);
  assign c[3] = gg | (pg & cin);

  assign pg = &sp;
  assign gg = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
            | (sp[3] & sp[2] & sp[1] & sg[0]);
endmodule

module sixteen_bit_full_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        p,
  output logic        g
);
  logic [3:0] slice_p;
  logic [3:0] slice_g;
  logic [3:0] slice_cin;
  logic [3:0] carries;

  assign slice_cin = {carries[2:0], cin};
  assign cout      = carries[3];

  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla4_slice u_slice (
      .a   (a[4*k +: 4]),
      .b   (b[4*k +: 4]),
      .cin (slice_cin[k]),
      .s   (sum[4*k +: 4]),
      .pg  (slice_p[k]),
      .gg  (slice_g[k])
    );
  end

  cla_lookahead u_lookahead (
    .sp  (slice_p),
    .sg  (slice_g),
    .cin (cin),
    .c   (carries),
    .pg  (p),
    .gg  (g)
  );
endmodule

module sm16_add_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] operand1,
  input  logic [15:0] operand2,
  input  logic        carry_in,
  output logic        out_valid,
  output logic [15:0] comp_1,
  output logic [15:0] comp_2,
  output logic [15:0] sum,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        p,
  output logic        g,
  output logic        overflow,
  output logic        zero_flag,
  output logic        negative_flag,
  output logic        carry_flag
);
  // Handshake: in_valid qualifies the operands for one cycle (no back-pressure);
  // out_valid pulses for exactly the cycle after an accepted operation.
  logic [15:0] norm_1;
  logic [15:0] norm_2;
  logic [15:0] c1_d;
  logic [15:0] c2_d;
  logic [15:0] sum_d;
  logic [15:0] result_d;
  logic        cout_d;
  logic        p_d;
  logic        g_d;
  logic        ovf_d;

  // Negative zero has no distinct two's-complement encoding; fold it to +0.
  assign norm_1 = (operand1 == 16'h8000) ? 16'h0000 : operand1;
  assign norm_2 = (operand2 == 16'h8000) ? 16'h0000 : operand2;

  complement u_comp_1 (.x(norm_1), .y(c1_d));
  complement u_comp_2 (.x(norm_2), .y(c2_d));

  sixteen_bit_full_adder u_adder (
    .a    (c1_d),
    .b    (c2_d),
    .cin  (carry_in),
    .sum  (sum_d),
    .cout (cout_d),
    .p    (p_d),
    .g    (g_d)
  );

  // A sum of 0x8000 maps back to 0x8000, the closest sign-magnitude pattern.
  complement u_comp_res (.x(sum_d), .y(result_d));

  assign ovf_d = (c1_d[15] == c2_d[15]) && (sum_d[15] != c1_d[15]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      comp_1        <= 16'h0000;
      comp_2        <= 16'h0000;
      sum           <= 16'h0000;
      result        <= 16'h0000;
      carry_out     <= 1'b0;
      p             <= 1'b0;
      g             <= 1'b0;
      overflow      <= 1'b0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        comp_1        <= c1_d;
        comp_2        <= c2_d;
        sum           <= sum_d;
        result        <= result_d;
        carry_out     <= cout_d;
        p             <= p_d;
        g             <= g_d;
        overflow      <= ovf_d;
        zero_flag     <= (sum_d == 16'h0000);
        negative_flag <= sum_d[15];
        carry_flag    <= cout_d;
      end
    end
  end
endmodule

// File: tb/tb_sm16_add_unit.sv
// Bench for sm16_add_unit: directed vectors with hand-computed expectations, a
// scoreboard queue filled by the driver and drained by an independent monitor.

module tb_sm16_add_unit;
  localparam int W = 71;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic        carry_in;
  logic        out_valid;
  logic [15:0] comp_1;
  logic [15:0] comp_2;
  logic [15:0] sum;
  logic [15:0] result;
  logic        carry_out;
  logic        p;
  logic        g;
  logic        overflow;
  logic        zero_flag;
  logic        negative_flag;
  logic        carry_flag;

  sm16_add_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .operand1      (operand1),
    .operand2      (operand2),
    .carry_in      (carry_in),
    .out_valid     (out_valid),
    .comp_1        (comp_1),
    .comp_2        (comp_2),
    .sum           (sum),
    .result        (result),
    .carry_out     (carry_out),
    .p             (p),
    .g             (g),
    .overflow      (overflow),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .carry_flag    (carry_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  // Expected word layout: {comp_1, comp_2, sum, result, co, p, g, ov, z, n, cf}
  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic        cin;
    logic [W-1:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  function automatic logic [W-1:0] mk(input logic [15:0] c1, input logic [15:0] c2,
                                      input logic [15:0] s, input logic [15:0] r,
                                      input logic [6:0] flags);
    return {c1, c2, s, r, flags};
  endfunction

  initial begin
    // flags order: co p g ov z n cf
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000100)};
    vecs[1] = '{16'h0001, 16'h0002, 1'b1, mk(16'h0001, 16'h0002, 16'h0004, 16'h0004, 7'b0000000)};
    vecs[2] = '{16'hFFFF, 16'hFFFE, 1'b0, mk(16'h8001, 16'h8002, 16'h0003, 16'h0003, 7'b1011001)};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'b0000100)};
    vecs[4] = '{16'h0000, 16'h8001, 1'b1, mk(16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 7'b1100101)};
    vecs[5] = '{16'h0003, 16'h8005, 1'b0, mk(16'h0003, 16'hFFFB, 16'hFFFE, 16'h8002, 7'b0000010)};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, mk(16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 7'b0001010)};
    vecs[7] = '{16'h1234, 16'h0F0F, 1'b0, mk(16'h1234, 16'h0F0F, 16'h2143, 16'h2143, 7'b0000000)};
    vecs[8] = '{16'h8001, 16'h8001, 1'b1, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8001, 7'b1010011)};
    vecs[9] = '{16'h8000, 16'h0005, 1'b1, mk(16'h0000, 16'h0005, 16'h0006, 16'h0006, 7'b0000000)};
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_exp;
  logic         have_last = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {comp_1, comp_2, sum, result,
            carry_out, p, g, overflow, zero_flag, negative_flag, carry_flag};
  endfunction

  task automatic cmp_all(input string tag, input logic [W-1:0] e);
    logic [W-1:0] a;
    a = observed();
    chk({tag, ".comp_1"},        a[70:55],       e[70:55]);
    chk({tag, ".comp_2"},        a[54:39],       e[54:39]);
    chk({tag, ".sum"},           a[38:23],       e[38:23]);
    chk({tag, ".result"},        a[22:7],        e[22:7]);
    chk({tag, ".carry_out"},     {15'd0, a[6]},  {15'd0, e[6]});
    chk({tag, ".p"},             {15'd0, a[5]},  {15'd0, e[5]});
    chk({tag, ".g"},             {15'd0, a[4]},  {15'd0, e[4]});
    chk({tag, ".overflow"},      {15'd0, a[3]},  {15'd0, e[3]});
    chk({tag, ".zero_flag"},     {15'd0, a[2]},  {15'd0, e[2]});
    chk({tag, ".negative_flag"}, {15'd0, a[1]},  {15'd0, e[1]});
    chk({tag, ".carry_flag"},    {15'd0, a[0]},  {15'd0, e[0]});
  endtask

  // Monitor: pops on every out_valid; on idle cycles checks the held values.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        last_exp  = exp_q.pop_front();
        have_last = 1'b1;
        cmp_all("result", last_exp);
      end
    end else if (have_last) begin
      cmp_all("hold", last_exp);
    end
  end

  // ---------------- driver ----------------
  task automatic drive_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand1 = 16'($urandom_range(0, 16'hFFFF));
    operand2 = 16'($urandom_range(0, 16'hFFFF));
    carry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_vec(input int i);
    @(posedge clk); #1;
    in_valid = 1'b1;
    operand1 = vecs[i].op1;
    operand2 = vecs[i].op2;
    carry_in = vecs[i].cin;
    exp_q.push_back(vecs[i].exp);
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      operand1 = 16'($urandom_range(0, 16'hFFFF));
      operand2 = 16'($urandom_range(0, 16'hFFFF));
      carry_in = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cmp_all("reset", '0);
    chk("reset.out_valid", {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    operand1 = 16'h0000;
    operand2 = 16'h0000;
    carry_in = 1'b0;

    do_reset(2);

    // Release reset and issue immediately: result must appear one cycle later.
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    operand1 = vecs[0].op1;
    operand2 = vecs[0].op2;
    carry_in = vecs[0].cin;
    exp_q.push_back(vecs[0].exp);

    // Back-to-back stream.
    for (int i = 1; i < NV; i++) drive_vec(i);

    // Idle cycles: outputs must hold the last result.
    for (int k = 0; k < 3; k++) drive_idle();

    // Sparse issue with gaps in between.
    for (int i = NV - 1; i >= 0; i -= 3) begin
      drive_vec(i);
      drive_idle();
      drive_idle();
    end

    // Mid-run reset with in_valid high: the operation is discarded.
    do_reset(2);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive_vec(6);
    drive_idle();

    begin : drain
      int budget;
      budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sm16_add_unit.md
# sm16_add_unit

Registered 16-bit sign-magnitude adder with status flags for the datapath's arithmetic stage. Each operand is converted from sign-magnitude to two's complement and added with a carry-in by a two-level carry-lookahead adder. The sum is converted back to sign-magnitude, and all outputs are registered. The block contains the `complement` converter and the `sixteen_bit_full_adder` as submodules.

## Interface
No parameters.

One clock; reset is synchronous and active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid this cycle
- operand1  in  16  operand A, sign-magnitude (bit 15 = sign)
- operand2  in  16  operand B, sign-magnitude
- carry_in  in  1  adder carry-in
- out_valid  out  1  registered outputs hold a new result
- comp_1  out  16  operand A in two's complement
- comp_2  out  16  operand B in two's complement
- sum  out  16  two's-complement sum, comp_1 + comp_2 + carry_in, mod 2^16
- result  out  16  sum converted to sign-magnitude
- carry_out  out  1  carry out of bit 15
- p  out  1  group propagate, AND over i of (comp_1[i] ^ comp_2[i])
- g  out  1  group generate: the carry out of the 16-bit group with carry_in = 0
- overflow  out  1  signed overflow
- zero_flag  out  1  sum == 0
- negative_flag  out  1  sum[15]
- carry_flag  out  1  equals carry_out

## Operation
- complement(x):
  - if x[15] = 0, the output is x unchanged;
  - otherwise the output is {1'b1, (~x[14:0] + 1)[14:0]}.
- The same function is used for input conversion and for output conversion.
- Negative zero is normalized before conversion: an operand of 0x8000 is treated as 0x0000, so comp_n = 0x0000.
- Output conversion: result = complement(sum).
  - A sum of 0x8000 (-32768, not representable in sign-magnitude) gives result = 0x8000.
- The adder is built from four 4-bit lookahead slices. Each slice produces bit-level p = a^b, g = a&b, and slice-level P and G.
- A second-level lookahead unit computes the slice carries c4, c8, c12 and c16 from the slice P/G and carry_in. There is no ripple between slices.
- carry_out = c16.
- overflow = (comp_1[15] == comp_2[15]) && (sum[15] != comp_1[15]).
- zero_flag, negative_flag and carry_flag are derived from the sum and carry_out of the same operation.
- All outputs are computed combinationally from the inputs and captured in one output register stage.
- When in_valid = 0, the output registers hold their previous values and out_valid = 0 on the next cycle.

## Timing
- Latency is 1 cycle. Inputs are sampled at posedge N with in_valid = 1; all outputs reflect them after posedge N and out_valid = 1 for that cycle.
- Throughput is one operation per cycle; back-to-back in_valid is allowed with no bubbles.
- Reset: when rst_n = 0 at a posedge, all outputs clear to 0, including out_valid and zero_flag.
  - Reset has priority over in_valid.
  - An operation sampled in the same cycle as reset is discarded.
- There is no combinational path from the inputs to the outputs.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 and arbitrary operands -> all outputs 0 and out_valid = 0; the first valid result appears 1 cycle after rst_n rises.
- Zero add: 0x0000 + 0x0000, carry_in = 0 -> sum = 0x0000, result = 0x0000, zero_flag = 1, carry_out = 0, overflow = 0, p = 0, g = 0.
- Positive add: 0x0001 + 0x0002, carry_in = 1 -> sum = 0x0004, result = 0x0004, all flags 0.
- Negative overflow: 0xFFFF + 0xFFFE, carry_in = 0 (sign-magnitude -32767 + -32766):
  - comp_1 = 0x8001, comp_2 = 0x8002;
  - sum = 0x0003, carry_out = 1, carry_flag = 1, overflow = 1, negative_flag = 0, result = 0x0003.
- Negative zero: 0x8000 + 0x8000, carry_in = 0 -> comp_1 = comp_2 = 0x0000, sum = 0x0000, zero_flag = 1, carry_out = 0, overflow = 0.
- Full propagate: 0x0000 + 0x8001 (-1 -> 0xFFFF), carry_in = 1 -> p = 1, g = 0, sum = 0x0000, carry_out = 1, zero_flag = 1, result = 0x0000.
- Also cover: back-to-back operations on consecutive cycles, and in_valid = 0 holding the previous outputs.
